data_gen_sata: RTL and testbench
================================

// Module: data_gen_sata
// PURPOSE
// - Transmit-side test-pattern source for SATA data-path bring-up.
// - Emits a burst of mod-256 incrementing bytes under a valid/ack handshake.
// - The downstream checker flags any step other than +1.
// - Supports one-shot error injection, so the checker's err path can be proven in the lab.
// - Sits between the test-control registers and the SATA transport write path.
// PARAMETERS
// - LEN_W   16    width of the burst-length and byte-count fields
// PORTS
// - clk          in   1      clock
// - nRST         in   1      reset, asynchronous, active-low
// - start        in   1      1-cycle pulse: begin burst (honoured in IDLE only)
// - stop         in   1      synchronous abort of the running burst
// - len          in   LEN_W  burst length in bytes, sampled on start
// - seed         in   8      first byte value, sampled on start
// - inject_err   in   1      request one skipped value (+2 step) in the stream
// - ack          in   1      consumer accepts data_out this cycle
// - data_out     out  8      pattern byte
// - valid        out  1      data_out is offered
// - busy         out  1      burst in progress (state RUN)
// - done         out  1      1-cycle pulse after the last byte is accepted
// - inj_done     out  1      1-cycle pulse on the ack that carried the injected step
// - byte_cnt     out  LEN_W  bytes accepted in the current/last burst
// BEHAVIOUR
// - Reset: state=IDLE; data_out=0, valid=0, busy=0, done=0, inj_done=0, byte_cnt=0, inj_pend=0.
// - FSM states: IDLE, RUN, DONE.
// - IDLE
//   - start && len!=0 -> RUN next edge.
//   - On that edge: remaining<=len; byte_cnt<=0; data_out<=(seed==0 ? 8'h01 : seed); valid<=1.
//   - start && len==0 -> ignored; stay IDLE with no outputs changed.
// - RUN
//   - valid=1 and busy=1.
//   - data_out is held stable until ack.
//   - An ack is a transfer: valid && ack at a clock edge.
//   - Zero latency: the byte present during the ack cycle is the accepted byte.
//   - On each transfer: remaining--, byte_cnt++, data_out advances by +1 (mod 256; 0xFF->0x00 is legal).
// - Last transfer (remaining==1)
//   - -> DONE; valid=0 and busy=0 on the same edge.
//   - data_out still advances one step.
// - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
// - stop in RUN
//   - -> IDLE next edge; valid=0, busy=0; done is not pulsed.
//   - stop && transfer in the same cycle: the byte is counted (byte_cnt++), then abort.
// - start while in RUN or DONE: ignored (no restart, no re-sample).
// - Error injection
//   - inject_err (any state) sets inj_pend.
//   - inj_pend is cleared by start in IDLE, by stop, and on use.
//   - A transfer in RUN with inj_pend=1 and data_out not in {8'h00, 8'hFE}:
//     - step is +2 instead of +1;
//     - inj_pend clears;
//     - inj_done pulses 1 cycle.
//   - Excluded values are deferred to the next transfer, because the checker treats 0x00 as a wildcard.
// - byte_cnt is held after DONE/abort until the next accepted start.
//   - Wraps at 2^LEN_W (cannot exceed len).
// - nRST asserted mid-burst: immediate return to reset values; no done pulse.
// - ack outside RUN: ignored.
// STRUCTURE
// - Shared package sata_test_pkg:
//   - state encoding localparams (IDLE/RUN/DONE);
//   - PAT_STEP=8'h01, INJ_STEP=8'h02;
//   - the 0x00/0xFE injection-exclusion constants.
// - Single flat module, no sub-module:
//   - FSM, byte/remaining counters, and the pattern register with injection mux.
// TESTING
// - start, len=5, seed=8'h10, ack held 1 -> data_out 10,11,12,13,14 on successive transfers;
//   done pulses 1 cycle after the 5th; byte_cnt=5.
// - ack toggled 1-0-0-1 -> data_out stable while ack=0; no byte skipped or repeated.
// - seed=8'hFE, len=4 -> FE,FF,00,01 accepted; checker driven in loop reports err=0.
// - inject_err while data_out=8'h20 -> next byte 8'h22; inj_done pulses 1 cycle; checker err rises.
// - inject_err with data_out=8'hFE -> injection deferred; FE,FF accepted, then 01 (+2 step).
// - stop on the 3rd of 10 transfers -> byte_cnt=3; valid=0 next cycle; no done;
//   start mid-burst ignored; nRST mid-burst -> all outputs 0.

Source files
------------

// File: rtl/sata_test_pkg.sv
// Shared constants for the SATA test-pattern generator: state encoding,
// pattern/injection step sizes and the values that may not carry an injected step.
package sata_test_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

    localparam logic [7:0] PAT_STEP    = 8'h01;
    localparam logic [7:0] INJ_STEP    = 8'h02;
    // The checker treats 0x00 as a wildcard, so a +2 step must never land on or leave from it.
    localparam logic [7:0] INJ_EXCL_LO = 8'h00;
    localparam logic [7:0] INJ_EXCL_HI = 8'hFE;

    function automatic logic [7:0] first_byte(input logic [7:0] seed);
        return (seed == 8'h00) ? 8'h01 : seed;
    endfunction

endpackage

// File: rtl/data_gen_sata_if.sv
// Control, handshake and status bundle between test-control logic and the pattern generator.
interface data_gen_sata_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             stop;
    logic [LEN_W-1:0] len;
    logic [7:0]       seed;
    logic             inject_err;
    logic             ack;
    logic [7:0]       data_out;
    logic             valid;
    logic             busy;
    logic             done;
    logic             inj_done;
    logic [LEN_W-1:0] byte_cnt;

    modport master (
        input  start, stop, len, seed, inject_err, ack,
        output data_out, valid, busy, done, inj_done, byte_cnt
    );

    modport slave (
        output start, stop, len, seed, inject_err, ack,
        input  data_out, valid, busy, done, inj_done, byte_cnt
    );
endinterface

// File: rtl/data_gen_sata.sv
// Incrementing-byte burst source with valid/ack handshake, abort and one-shot
// +2 error injection for proving the downstream checker.
module data_gen_sata
    import sata_test_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  nRST,
    data_gen_sata_if.master       bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_byte_cnt;
    logic [7:0]       r_data;
    logic             r_inj_pend;
    logic             r_inj_done;

    logic             w_start_ok;
    logic             w_xfer;
    logic             w_inj_use;
    logic [7:0]       w_data_step;

    assign w_start_ok  = (r_state == ST_IDLE) && bus.start && (bus.len != '0);
    assign w_xfer      = (r_state == ST_RUN) && bus.ack;
    assign w_inj_use   = w_xfer && r_inj_pend &&
                         (r_data != INJ_EXCL_LO) && (r_data != INJ_EXCL_HI);
    assign w_data_step = r_data + (w_inj_use ? INJ_STEP : PAT_STEP);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_next = ST_RUN;
            ST_RUN: begin
                if (bus.stop)
                    w_state_next = ST_IDLE;
                else if (w_xfer && (r_remaining == LEN_W'(1)))
                    w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_byte_cnt  <= '0;
            r_data      <= 8'h00;
            r_inj_pend  <= 1'b0;
            r_inj_done  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inj_done <= w_inj_use;

            if (w_start_ok) begin
                r_remaining <= bus.len;
                r_byte_cnt  <= '0;
                r_data      <= first_byte(bus.seed);
            end else if (w_xfer) begin
                r_remaining <= r_remaining - LEN_W'(1);
                r_byte_cnt  <= r_byte_cnt + LEN_W'(1);
                r_data      <= w_data_step;
            end

            // A new request wins over a same-cycle clear so it is never lost.
            if (bus.inject_err)
                r_inj_pend <= 1'b1;
            else if (((r_state == ST_IDLE) && bus.start) || bus.stop || w_inj_use)
                r_inj_pend <= 1'b0;
        end
    end

    assign bus.data_out = r_data;
    assign bus.valid    = (r_state == ST_RUN);
    assign bus.busy     = (r_state == ST_RUN);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.inj_done = r_inj_done;
    assign bus.byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_data_gen_sata.sv
// Directed self-checking bench for data_gen_sata with a small inline model of the
// downstream +1 checker (0x00 accepted as wildcard).
module tb_data_gen_sata;
    import sata_test_pkg::*;

    localparam int LEN_W = 16;

    logic clk;
    logic nRST;
    int   n_cmp;
    int   n_bad;

    logic       chk_prev_ok;
    logic [7:0] chk_prev;
    logic       chk_err;

    data_gen_sata_if #(.LEN_W(LEN_W)) bus ();

    data_gen_sata #(.LEN_W(LEN_W)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_model();
        chk_prev_ok = 1'b0;
        chk_prev    = 8'h00;
        chk_err     = 1'b0;
    endtask

    // Presents ack for one cycle, checks the offered byte, feeds the checker model.
    task automatic accept(input string tag, input logic [7:0] exp);
        bus.ack = 1'b1;
        check_val({tag, "_valid"}, 32'(bus.valid), 32'd1);
        check_val({tag, "_data"}, 32'(bus.data_out), 32'(exp));
        if (chk_prev_ok && (bus.data_out != 8'h00) && (bus.data_out != chk_prev + 8'h01))
            chk_err = 1'b1;
        chk_prev    = bus.data_out;
        chk_prev_ok = 1'b1;
        $display("xfer %s: data=0x%02h cnt=%0d", tag, bus.data_out, bus.byte_cnt);
        step();
    endtask

    task automatic begin_burst(input logic [15:0] l, input logic [7:0] s);
        bus.start = 1'b1;
        bus.len   = l;
        bus.seed  = s;
        step();
        bus.start = 1'b0;
        chk_reset_model();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk_reset_model();
        nRST           = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.len        = '0;
        bus.seed       = 8'h00;
        bus.inject_err = 1'b0;
        bus.ack        = 1'b0;
        step();
        step();
        check_val("rst_data", 32'(bus.data_out), 32'h0);
        check_val("rst_valid", 32'(bus.valid), 32'h0);
        check_val("rst_busy", 32'(bus.busy), 32'h0);
        check_val("rst_done", 32'(bus.done), 32'h0);
        check_val("rst_inj_done", 32'(bus.inj_done), 32'h0);
        check_val("rst_cnt", 32'(bus.byte_cnt), 32'h0);
        nRST = 1'b1;
        step();

        // start with len=0 is ignored
        begin_burst(16'd0, 8'h33);
        check_val("len0_busy", 32'(bus.busy), 32'h0);
        check_val("len0_data", 32'(bus.data_out), 32'h0);

        // len=5, seed=0x10, ack held
        begin_burst(16'd5, 8'h10);
        check_val("b1_busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 5; i++) accept($sformatf("b1_%0d", i), 8'h10 + 8'(i));
        bus.ack = 1'b0;
        check_val("b1_done", 32'(bus.done), 32'h1);
        check_val("b1_valid_end", 32'(bus.valid), 32'h0);
        check_val("b1_cnt", 32'(bus.byte_cnt), 32'd5);
        step();
        check_val("b1_done_off", 32'(bus.done), 32'h0);
        check_val("b1_cnt_hold", 32'(bus.byte_cnt), 32'd5);

        // ack 1-0-0-1: byte held while ack low
        begin_burst(16'd4, 8'h40);
        accept("b2_0", 8'h40);
        bus.ack = 1'b0;
        check_val("b2_hold1", 32'(bus.data_out), 32'h41);
        step();
        check_val("b2_hold2", 32'(bus.data_out), 32'h41);
        step();
        check_val("b2_cnt_mid", 32'(bus.byte_cnt), 32'd1);
        accept("b2_1", 8'h41);
        accept("b2_2", 8'h42);
        accept("b2_3", 8'h43);
        bus.ack = 1'b0;
        check_val("b2_done", 32'(bus.done), 32'h1);
        check_val("b2_chk_err", 32'(chk_err), 32'h0);
        step();

        // wrap through 0xFF -> 0x00
        begin_burst(16'd4, 8'hFE);
        accept("b3_0", 8'hFE);
        accept("b3_1", 8'hFF);
        accept("b3_2", 8'h00);
        accept("b3_3", 8'h01);
        bus.ack = 1'b0;
        check_val("b3_chk_err", 32'(chk_err), 32'h0);
        check_val("b3_done", 32'(bus.done), 32'h1);
        step();

        // injection at 0x20 -> 0x22
        begin_burst(16'd4, 8'h20);
        bus.inject_err = 1'b1;
        step();
        bus.inject_err = 1'b0;
        accept("b4_0", 8'h20);
        check_val("b4_inj_done", 32'(bus.inj_done), 32'h1);
        accept("b4_1", 8'h22);
        check_val("b4_inj_done_off", 32'(bus.inj_done), 32'h0);
        accept("b4_2", 8'h23);
        accept("b4_3", 8'h24);
        bus.ack = 1'b0;
        check_val("b4_chk_err", 32'(chk_err), 32'h1);
        step();

        // injection deferred past 0xFE
        begin_burst(16'd4, 8'hFE);
        bus.inject_err = 1'b1;
        step();
        bus.inject_err = 1'b0;
        accept("b5_0", 8'hFE);
        check_val("b5_inj_defer", 32'(bus.inj_done), 32'h0);
        accept("b5_1", 8'hFF);
        check_val("b5_inj_done", 32'(bus.inj_done), 32'h1);
        accept("b5_2", 8'h01);
        accept("b5_3", 8'h02);
        bus.ack = 1'b0;
        check_val("b5_done", 32'(bus.done), 32'h1);
        step();

        // stop on the 3rd of 10 transfers
        begin_burst(16'd10, 8'h50);
        accept("b6_0", 8'h50);
        accept("b6_1", 8'h51);
        bus.stop = 1'b1;
        accept("b6_2", 8'h52);
        bus.stop = 1'b0;
        bus.ack  = 1'b0;
        check_val("b6_valid", 32'(bus.valid), 32'h0);
        check_val("b6_busy", 32'(bus.busy), 32'h0);
        check_val("b6_cnt", 32'(bus.byte_cnt), 32'd3);
        check_val("b6_no_done", 32'(bus.done), 32'h0);
        step();
        check_val("b6_no_done2", 32'(bus.done), 32'h0);

        // start mid-burst ignored, then async reset mid-burst
        begin_burst(16'd10, 8'h60);
        accept("b7_0", 8'h60);
        bus.ack   = 1'b0;
        bus.start = 1'b1;
        bus.len   = 16'd2;
        bus.seed  = 8'h99;
        step();
        bus.start = 1'b0;
        check_val("b7_restart_data", 32'(bus.data_out), 32'h61);
        check_val("b7_restart_busy", 32'(bus.busy), 32'h1);
        check_val("b7_restart_cnt", 32'(bus.byte_cnt), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_val("b7_rst_data", 32'(bus.data_out), 32'h0);
        check_val("b7_rst_valid", 32'(bus.valid), 32'h0);
        check_val("b7_rst_busy", 32'(bus.busy), 32'h0);
        check_val("b7_rst_cnt", 32'(bus.byte_cnt), 32'h0);
        step();
        check_val("b7_rst_done", 32'(bus.done), 32'h0);
        nRST = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
